// File: rtl/seven_seg_if.sv
// Display-data bundle between the mode/format logic (master) and the
// seven-segment scanner (slave). Carries the per-digit nibbles and masks
// inbound and the board-level segment/digit drives outbound.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dec_points;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_blank;
    logic [3:0]              brightness;
    logic [7:0]              cathode;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_start;

    modport master (
        output enable, digits, dec_points, blank_mask, blink_mask, lz_blank, brightness,
        input  cathode, anode, frame_start
    );

    modport slave (
        input  enable, digits, dec_points, blank_mask, blink_mask, lz_blank, brightness,
        output cathode, anode, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment driver. Scans NUM_DIGITS digits,
// one TICK_DIV-cycle slot each, with a 16-level PWM window on the anode,
// per-frame input snapshot, blanking, blinking and leading-zero suppression.
// Cathodes and anodes are active-low; all outputs are registered.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clock,
    input  logic       reset,
    seven_seg_if.slave io
);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int PWM_STEP = TICK_DIV / 16;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    // Standard hex decode, active-low, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    logic [TICK_W-1:0]       tick_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_lz;

    logic [NUM_DIGITS-1:0]   anode_p1;
    logic [7:0]              cathode_p1;
    logic                    frame_start_p1;

    logic                    tick_wrap;
    logic                    frame_wrap;
    logic                    frame_load;

    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic [NUM_DIGITS-1:0]   eff_blink;
    logic                    eff_lz;
    logic [NUM_DIGITS-1:0]   lead_zero;

    logic [3:0]              nib;
    logic [31:0]             pwm_limit;
    logic                    pwm_on;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [7:0]              cath_next;

    assign tick_wrap  = (tick_cnt == TICK_LAST);
    assign frame_wrap = io.enable && tick_wrap && (idx == IDX_LAST);
    // First processed cycle of slot 0: the frame's snapshot is taken here,
    // and this cycle already decodes from the live inputs being captured.
    // This also gives a fresh snapshot for the first frame after reset.
    assign frame_load = io.enable && (tick_cnt == '0) && (idx == '0);

    assign eff_digits = frame_load ? io.digits     : snap_digits;
    assign eff_dp     = frame_load ? io.dec_points : snap_dp;
    assign eff_blank  = frame_load ? io.blank_mask : snap_blank;
    assign eff_blink  = frame_load ? io.blink_mask : snap_blink;
    assign eff_lz     = frame_load ? io.lz_blank   : snap_lz;

    // Mark every digit whose nibble and all nibbles above it are zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (eff_digits[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end

    // Next-cycle anode/cathode for the current slot, blank > blink > lz > decode.
    always_comb begin
        nib        = eff_digits[{idx, 2'b00} +: 4];
        pwm_limit  = (32'(io.brightness) + 32'd1) * 32'(PWM_STEP);
        pwm_on     = (32'(tick_cnt) < pwm_limit);
        anode_next = '1;
        if (pwm_on) begin
            anode_next[idx] = 1'b0;
        end
        if (eff_blank[idx]) begin
            cath_next = 8'hFF;
        end else if (eff_blink[idx] && blink_phase) begin
            cath_next = 8'hFF;
        end else if (eff_lz && (idx != '0) && lead_zero[idx]) begin
            cath_next = {~eff_dp[idx], 7'h7F};
        end else begin
            cath_next = {~eff_dp[idx], hex_to_seg(nib)};
        end
    end

    // Slot timing: tick counter and digit index, frozen while disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else if (io.enable) begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Blink phase toggles every BLINK_FRAMES frames, only at frame wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Per-frame snapshot of the display content.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
        end else if (frame_load) begin
            snap_digits <= io.digits;
            snap_dp     <= io.dec_points;
            snap_blank  <= io.blank_mask;
            snap_blink  <= io.blink_mask;
            snap_lz     <= io.lz_blank;
        end
    end

    // Output register stage; disabling darkens anodes but keeps the cathode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode_p1       <= '1;
            cathode_p1     <= 8'hFF;
            frame_start_p1 <= 1'b0;
        end else if (io.enable) begin
            anode_p1       <= anode_next;
            cathode_p1     <= cath_next;
            frame_start_p1 <= frame_load;
        end else begin
            anode_p1       <= '1;
            frame_start_p1 <= 1'b0;
        end
    end

    assign io.anode       = anode_p1;
    assign io.cathode     = cathode_p1;
    assign io.frame_start = frame_start_p1;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (8 digits, 16-cycle slots, 2-frame blink).
// Stimulus pushes the expected sequence of lit anode windows; the monitor
// reassembles each window from the DUT pins and checks it against the queue.
`timescale 1ns/1ps
module tb_seven_seg_scanner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seven_seg_if #(.NUM_DIGITS(8)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS  (8),
        .TICK_DIV    (16),
        .BLINK_FRAMES(2)
    ) dut (
        .clock(clk),
        .reset(rst),
        .io   (bus)
    );

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] an;
        logic [7:0] cath;
        logic       fs;
        logic [7:0] len;
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Cathode patterns, byte k = digit k.
    localparam logic [63:0] T_MIX  = 64'hF9A4B099_8883C6A1; // 1234ABCD
    localparam logic [63:0] T_MIXB = 64'hF9A4B099_8883C6FF; // digit 0 dark
    localparam logic [63:0] T_LZ5  = 64'hFFFFFF7F_FF92C0C0; // 00000500, dp4
    localparam logic [63:0] T_LZ0  = 64'hFFFFFFFF_FFFFFFC0; // all zero
    localparam logic [63:0] T_ONES = 64'hF9F9F9F9_F9F9F9F9;
    localparam logic [63:0] T_TWOS = 64'hA4A4A4A4_A4A4A4A4;

    // Monitor state
    logic in_win = 1'b0;
    logic stable = 1'b1;
    win_t cur;
    win_t e;

    always @(negedge clk) begin
        if (in_win && bus.anode != cur.an) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (cur.an != e.an || cur.cath != e.cath || cur.fs != e.fs ||
                    cur.len != e.len || !stable) begin
                    errors++;
                    $display("FAIL t%0d window: got an=%h cath=%h fs=%b len=%0d steady=%b, required an=%h cath=%h fs=%b len=%0d steady=1",
                             e.tag, cur.an, cur.cath, cur.fs, cur.len, stable,
                             e.an, e.cath, e.fs, e.len);
                end
            end
            in_win = 1'b0;
        end
        if (!in_win && bus.anode != 8'hFF) begin
            in_win   = 1'b1;
            stable   = 1'b1;
            cur.tag  = 8'h00;
            cur.an   = bus.anode;
            cur.cath = bus.cathode;
            cur.fs   = bus.frame_start;
            cur.len  = 8'd1;
        end else if (in_win) begin
            cur.len = cur.len + 8'd1;
            if (bus.cathode != cur.cath || bus.frame_start) stable = 1'b0;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic void push(input int tag, input logic [7:0] an, input logic [7:0] cath,
                                 input logic fs, input logic [7:0] len);
        win_t w;
        w.tag  = 8'(tag);
        w.an   = an;
        w.cath = cath;
        w.fs   = fs;
        w.len  = len;
        exp_q.push_back(w);
    endfunction

    function automatic void push_frame(input int tag, input logic [63:0] cath, input logic [7:0] len);
        for (int k = 0; k < 8; k++) begin
            push(tag, ~(8'h01 << k), cath[8*k +: 8], (k == 0), len);
        end
    endfunction

    task automatic begin_reset(input string name);
        #1 rst = 1'b1;
        #1;
        check({name, " reset anode"},   bus.anode,   8'hFF);
        check({name, " reset cathode"}, bus.cathode, 8'hFF);
        check({name, " reset frame_start"}, {7'b0, bus.frame_start}, 8'h00);
        bus.enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic set_inputs(input logic [31:0] dg, input logic [7:0] dp, input logic [7:0] bl,
                              input logic [7:0] bk, input logic lz, input logic [3:0] br);
        bus.digits     = dg;
        bus.dec_points = dp;
        bus.blank_mask = bl;
        bus.blink_mask = bk;
        bus.lz_blank   = lz;
        bus.brightness = br;
        bus.enable     = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d windows still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable     = 1'b0;
        bus.digits     = '0;
        bus.dec_points = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        bus.lz_blank   = 1'b0;
        bus.brightness = 4'hF;

        // Plain scan, full brightness, two frames
        begin_reset("t1");
        set_inputs(32'h1234ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'hF);
        push_frame(1, T_MIX, 8'd16);
        push_frame(1, T_MIX, 8'd16);
        release_reset();
        drain("t1", 600);

        // PWM duty: brightness 3 -> 4 cycles, brightness 0 -> 1 cycle
        begin_reset("t2a");
        set_inputs(32'h1234ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'h3);
        push_frame(2, T_MIX, 8'd4);
        release_reset();
        drain("t2a", 400);
        begin_reset("t2b");
        set_inputs(32'h1234ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
        push_frame(2, T_MIX, 8'd1);
        release_reset();
        drain("t2b", 400);

        // Leading-zero suppression with a dp on a suppressed digit
        begin_reset("t3a");
        set_inputs(32'h00000500, 8'h10, 8'h00, 8'h00, 1'b1, 4'hF);
        push_frame(3, T_LZ5, 8'd16);
        release_reset();
        drain("t3a", 400);
        begin_reset("t3b");
        set_inputs(32'h00000000, 8'h00, 8'h00, 8'h00, 1'b1, 4'hF);
        push_frame(3, T_LZ0, 8'd16);
        release_reset();
        drain("t3b", 400);

        // Blink on digit 0 over eight frames, then blank overriding blink
        begin_reset("t4a");
        set_inputs(32'h1234ABCD, 8'h00, 8'h00, 8'h01, 1'b0, 4'h7);
        for (int f = 0; f < 8; f++) begin
            push_frame(4, (f == 2 || f == 3 || f == 6 || f == 7) ? T_MIXB : T_MIX, 8'd8);
        end
        release_reset();
        drain("t4a", 1500);
        begin_reset("t4b");
        set_inputs(32'h1234ABCD, 8'h00, 8'h01, 8'h01, 1'b0, 4'h7);
        for (int f = 0; f < 4; f++) push_frame(4, T_MIXB, 8'd8);
        release_reset();
        drain("t4b", 1000);

        // Mid-frame input change waits for the next frame
        begin_reset("t5");
        set_inputs(32'h11111111, 8'h00, 8'h00, 8'h00, 1'b0, 4'hF);
        push_frame(5, T_ONES, 8'd16);
        push_frame(5, T_TWOS, 8'd16);
        release_reset();
        repeat (52) @(posedge clk);
        #1 bus.digits = 32'h22222222;
        drain("t5", 600);

        // Reset during slot 5, fresh frame after release, enable gap in slot 2
        begin_reset("t6");
        set_inputs(32'h1234ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'hF);
        for (int k = 0; k < 5; k++) push(6, ~(8'h01 << k), T_MIX[8*k +: 8], (k == 0), 8'd16);
        push(6, 8'hDF, 8'hB0, 1'b0, 8'd4);
        release_reset();
        repeat (85) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6 mid reset anode",   bus.anode,   8'hFF);
        check("t6 mid reset cathode", bus.cathode, 8'hFF);
        check("t6 mid reset frame_start", {7'b0, bus.frame_start}, 8'h00);
        bus.digits = 32'h11111111;
        @(posedge clk);
        @(posedge clk);
        push(6, 8'hFE, 8'hF9, 1'b1, 8'd16);
        push(6, 8'hFD, 8'hF9, 1'b0, 8'd16);
        push(6, 8'hFB, 8'hF9, 1'b0, 8'd6);
        push(6, 8'hFB, 8'hF9, 1'b0, 8'd10);
        for (int k = 3; k < 8; k++) push(6, ~(8'h01 << k), 8'hF9, 1'b0, 8'd16);
        release_reset();
        repeat (38) @(posedge clk);
        #1 bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("t6 disabled anode",   bus.anode,   8'hFF);
        check("t6 disabled cathode", bus.cathode, 8'hF9);
        repeat (9) @(posedge clk);
        #1 bus.enable = 1'b1;
        drain("t6", 600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised multiplexed seven-segment driver. It scans NUM_DIGITS common-anode digits from a packed hex/BCD nibble bus and drives active-low cathodes. Beyond plain scanning it adds per-frame input snapshotting, 16-level PWM brightness, per-digit blanking, per-digit blink and leading-zero suppression. It sits between the mode/format logic (decimal, hex, time conversion) and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
TICK_DIV, 100000, clock cycles per digit slot; must be a multiple of 16 and at least 16
BLINK_FRAMES, 64, full scan frames per blink half-period (at least 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scan; 0 = all anodes off, counters hold
digits  in  4*NUM_DIGITS  nibble i = digits[4i+3:4i], digit 0 rightmost
dec_points  in  NUM_DIGITS  1 = decimal point lit on digit i
blank_mask  in  NUM_DIGITS  1 = digit i fully dark, including dp
blink_mask  in  NUM_DIGITS  1 = digit i dark during the blink-off phase
lz_blank  in  1  1 = suppress leading zeros
brightness  in  4  duty level 0..15; 15 = full on
cathode  out  8  active-low segments; [6:0] = g..a, [7] = dp
anode  out  NUM_DIGITS  active-low digit enables, one-hot-low
frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset values (asynchronous): anode all 1, cathode 8'hFF, frame_start 0. Also cleared: tick_cnt, idx, blink frame counter, blink phase, and all snapshot registers.
- tick_cnt counts 0..TICK_DIV-1 while enable=1 and wraps to 0.
  - On the wrap cycle, idx advances: idx==NUM_DIGITS-1 goes to 0, otherwise idx+1.
- Snapshot: when idx wraps to 0, latch digits, dec_points, blank_mask, blink_mask and lz_blank for the whole frame. Mid-frame input changes have no effect until the next frame.
- frame_start is registered. It is 1 for exactly the one cycle in which the outputs first show slot idx=0.
- All outputs are registered and lag idx/tick_cnt by one cycle.
- Slot output for idx=k:
  - The anode[k] bit is 0 only while tick_cnt < (brightness+1)*(TICK_DIV/16); every other anode bit is 1.
  - Outside that window all anodes are 1.
  - brightness is sampled live, not snapshotted.
- Digit k is dark (cathode 8'hFF) if any of these holds:
  - (a) blank_mask[k]=1 in the snapshot;
  - (b) blink_mask[k]=1 in the snapshot and blink phase = 1.
- Leading-zero suppression (lz_blank=1 in the snapshot): digit k with k>0 is zero-suppressed when its nibble is 0 and every nibble above it is 0.
  - Suppressed digits show cathode[6:0]=7'h7F. Their dp is still shown.
  - Digit 0 is never suppressed, so an all-zero value shows "0".
  - blank_mask digits count as zero-valued for this test only if their nibble is 0.
- Priority when conditions coincide: blank_mask, then blink, then leading-zero, then normal decode.
- Decode is standard hex 0-F, active-low (0 → 7'b1000000 in g..a order, F → 7'b0001110). cathode[7] = ~dp.
- Blink: a frame counter increments on each frame wrap. At BLINK_FRAMES-1 it clears and blink phase toggles. The phase changes only at frame boundaries.
- enable=0:
  - anode all 1 on the next cycle; cathode holds its last value.
  - tick_cnt, idx and the blink counters hold.
  - On re-enable, scanning resumes in the same slot at the held tick_cnt.
- Reset mid-operation: outputs return to the reset values immediately (asynchronously). The first slot after release is idx=0 with a fresh snapshot. frame_start pulses in the first enabled cycle after reset.
- With NUM_DIGITS=1, idx stays 0 and every slot is a frame start.

Test Plan:
1. NUM_DIGITS=8, TICK_DIV=16, brightness=15, digits=32'h1234ABCD, enable=1 → anode cycles FE,FD,...,7F every 16 cycles. Cathodes follow D,C,B,A,4,3,2,1, e.g. slot 0 = 8'hA1 (d) and slot 7 = 8'hF9 (1). frame_start pulses every 128 cycles.
2. brightness=3, TICK_DIV=16 → each anode is low for exactly 4 of 16 cycles per slot. brightness=0 → low for 1 cycle.
3. lz_blank=1, digits=32'h00000500, dec_points=8'h10 → digits 3..7 segments off; digit 4 cathode=8'h7F (dp only); digits 0..2 show 0,0,5. With digits=0 → only digit 0 shows 8'hC0.
4. BLINK_FRAMES=2, blink_mask=8'h01 → digit 0 cathode 8'hFF during frames 2-3 and 6-7, normal in frames 0-1 and 4-5. blank_mask=8'h01 also set → dark in every frame.
5. Change digits from 32'h11111111 to 32'h22222222 while idx=3 → slots 3..7 of the current frame still show 1. The next frame shows 2 in all slots.
6. Assert reset during slot 5, then deassert → anode=all 1 and cathode=8'hFF immediately. After release, the first active slot is digit 0 with frame_start=1. Drop enable for 10 cycles → anode all 1 and the slot resumes with its remaining tick count.
